mult_hilo_ctrl: RTL and testbench
=================================

Name: mult_hilo_ctrl

Overview:
- Sequential control and result-register stage wrapped around the 16x16 combinational array multiplier (`mult`).
- Upstream side: accepts an operand pair on a start/ready handshake and holds the operands registered on `mult_a`/`mult_b` while the array settles.
- Downstream side: after a fixed settle time, samples the multiplier's hi/lo outputs into architectural HI/LO registers, either overwriting or accumulating.
- Also supports direct HI/LO writes (move-to-HI/LO) for the datapath.

Parameters:
- LATENCY, 2, cycles the registered operands are held before the product is sampled; legal range 1..15.
- CNT_W, 4, width of the settle counter; must hold LATENCY.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a multiply; accepted only when ready=1.
- acc  in  1  sampled with start; 1 = {HI,LO} += product, 0 = {HI,LO} = product.
- signed_op  in  1  sampled with start; two's-complement multiply (only honoured with the optional feature).
- op_a  in  16  multiplicand, sampled with start.
- op_b  in  16  multiplier, sampled with start.
- ready  out  1  block idle, can accept start or HI/LO writes.
- mult_a  out  16  registered operand A to the multiplier.
- mult_b  out  16  registered operand B to the multiplier.
- mult_hi  in  16  multiplier product bits 31:16.
- mult_lo  in  16  multiplier product bits 15:0.
- hi_we  in  1  write wdata into HI.
- lo_we  in  1  write wdata into LO.
- wdata  in  16  data for hi_we/lo_we.
- hi  out  16  HI register.
- lo  out  16  LO register.
- done  out  1  one-cycle pulse: HI/LO updated by a multiply.

Behaviour:
- Reset (async, rst_n=0): state IDLE, hi=lo=0, mult_a=mult_b=0, counter=0, acc/signed flags=0, ready=1, done=0. Reset mid-multiply abandons it: no HI/LO update, no done.
- States:
  - IDLE: ready=1. On an edge with start=1, capture op_a/op_b into mult_a/mult_b, latch acc and signed_op, load counter=LATENCY, go to WAIT.
  - WAIT: ready=0. Each edge: if counter==1, write HI/LO, set done=1 for the next cycle, go to IDLE. Otherwise decrement the counter.
- Timing: start accepted at edge t; HI/LO written at edge t+LATENCY. done=1 and ready=1 during the cycle following edge t+LATENCY. Back-to-back start in that cycle is legal.
- done is registered, high exactly one cycle per completed multiply; 0 otherwise.
- mult_a/mult_b hold their value until the next accepted start; they are not cleared on completion.
- Product P = {mult_hi, mult_lo}, sampled at the write edge.
  - acc=0: {hi,lo} <= P.
  - acc=1: {hi,lo} <= {hi,lo} + P, modulo 2^32. The carry from lo to hi is propagated; the carry out of bit 31 is dropped.
- hi_we/lo_we: honoured only when ready=1 and ignored in WAIT. Both may fire in the same cycle.
- If start and hi_we/lo_we arrive in the same IDLE cycle, the direct write takes effect at that edge and the multiply proceeds normally. A later acc=1 multiply accumulates onto the written value.
- start while ready=0 is ignored: no queueing, operands dropped.
- Output hi/lo change only on a multiply write, a direct write, or reset.

Optional Feature:
- Macro: MULT_SIGNED_EN.
- Defined: when the latched signed_op=1, the unsigned product is sign-corrected before the write/accumulate.
  - hi_corr = mult_hi − (mult_a[15] ? mult_b : 0) − (mult_b[15] ? mult_a : 0), modulo 2^16.
  - lo is unchanged.
  - signed_op=0 behaves as unsigned.
- Not defined: signed_op is ignored and all multiplies are unsigned. No correction logic is synthesized.

Test Plan:
- Reset, then start op_a=3 op_b=5 acc=0 (LATENCY=2) → ready=0 for 2 cycles; done pulses; hi=0x0000 lo=0x000F.
- start 0xFFFF×0xFFFF acc=0 → hi=0xFFFE lo=0x0001. Then lo_we wdata=0x0001 plus hi_we wdata=0x0000, then start 0xFFFF×0xFFFF acc=1 → hi=0xFFFE lo=0x0002. Then lo_we=0xFFFF, hi_we=0x0000, start 1×1 acc=1 → hi=0x0001 lo=0x0000 (carry propagates from lo into hi).
- While in WAIT: pulse start with op_a=7 and assert hi_we=1 wdata=0x1234 → both ignored; result equals the first operands' product; only one done pulse.
- Assert start in the same cycle done is high → second multiply accepted; its HI/LO write lands LATENCY edges later.
- Assert rst_n=0 one cycle after start → hi/lo stay 0, done never pulses, ready=1 after release.
- With MULT_SIGNED_EN, signed_op=1: 0xFFFE×0x0003 → hi=0xFFFF lo=0xFFFA; 0xFFFF×0xFFFF → hi=0x0000 lo=0x0001. Without the macro, 0xFFFE×0x0003 → hi=0x0002 lo=0xFFFA.

Source files
------------

// File: rtl/mult_hilo_ctrl.sv
// Control and HI/LO result-register stage around an external 16x16 combinational multiplier.
// Optional signed-product correction is built only when MULT_SIGNED_EN is defined.
module mult_hilo_ctrl #(
    parameter int LATENCY = 2,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        acc,
    input  logic        signed_op,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        ready,
    output logic [15:0] mult_a,
    output logic [15:0] mult_b,
    input  logic [15:0] mult_hi,
    input  logic [15:0] mult_lo,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [15:0] wdata,
    output logic [15:0] hi,
    output logic [15:0] lo,
    output logic        done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             acc_q, acc_d;
    logic [15:0]      mult_a_q, mult_a_d;
    logic [15:0]      mult_b_q, mult_b_d;
    logic [15:0]      hi_q, hi_d;
    logic [15:0]      lo_q, lo_d;
    logic             done_q, done_d;
    logic [15:0]      prod_hi;
    logic [31:0]      prod;
    logic             accept;

    assign accept = (state_q == S_IDLE) && start;

`ifdef MULT_SIGNED_EN
    logic sgn_q, sgn_d;

    always_comb begin
        sgn_d = sgn_q;
        if (accept) begin
            sgn_d = signed_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgn_q <= 1'b0;
        end else begin
            sgn_q <= sgn_d;
        end
    end

    // The array is unsigned; subtracting each operand where the other is negative
    // turns the upper half into the two's-complement product's upper half.
    always_comb begin
        prod_hi = mult_hi;
        if (sgn_q) begin
            prod_hi = mult_hi - (mult_a_q[15] ? mult_b_q : 16'd0)
                              - (mult_b_q[15] ? mult_a_q : 16'd0);
        end
    end
`else
    logic unused_signed_op;
    assign unused_signed_op = signed_op;
    assign prod_hi          = mult_hi;
`endif

    assign prod = {prod_hi, mult_lo};

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves one unassigned (no latches).
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mult_a_d = mult_a_q;
        mult_b_d = mult_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (hi_we) begin
                    hi_d = wdata;
                end
                if (lo_we) begin
                    lo_d = wdata;
                end
                if (start) begin
                    mult_a_d = op_a;
                    mult_b_d = op_b;
                    acc_d    = acc;
                    cnt_d    = CNT_W'(LATENCY);
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    {hi_d, lo_d} = acc_q ? ({hi_q, lo_q} + prod) : prod;
                    done_d       = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= 1'b0;
            mult_a_q <= '0;
            mult_b_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mult_a_q <= mult_a_d;
            mult_b_q <= mult_b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign ready  = (state_q == S_IDLE);
    assign mult_a = mult_a_q;
    assign mult_b = mult_b_q;
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign done   = done_q;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Directed self-checking bench for mult_hilo_ctrl with an unsigned array multiplier model.
// Signed-correction vectors follow MULT_SIGNED_EN.
module tb_mult_hilo_ctrl;

    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, acc, signed_op;
    logic [15:0] op_a, op_b;
    logic        ready;
    logic [15:0] mult_a, mult_b;
    logic [15:0] mult_hi, mult_lo;
    logic        hi_we, lo_we;
    logic [15:0] wdata;
    logic [15:0] hi, lo;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Combinational unsigned 16x16 array multiplier.
    logic [31:0] array_prod;
    assign array_prod        = {16'd0, mult_a} * {16'd0, mult_b};
    assign {mult_hi, mult_lo} = array_prod;

    mult_hilo_ctrl #(.LATENCY(LATENCY), .CNT_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .acc      (acc),
        .signed_op(signed_op),
        .op_a     (op_a),
        .op_b     (op_b),
        .ready    (ready),
        .mult_a   (mult_a),
        .mult_b   (mult_b),
        .mult_hi  (mult_hi),
        .mult_lo  (mult_lo),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .hi       (hi),
        .lo       (lo),
        .done     (done)
    );

    // Drive a start for one edge; returns just after the accepting edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic ac, input logic sg);
        start = 1'b1; op_a = a; op_b = b; acc = ac; signed_op = sg;
        @(negedge clk);
        start = 1'b0; op_a = 16'h0; op_b = 16'h0; acc = 1'b0; signed_op = 1'b0;
    endtask

    // Count negedges until done is seen, bounded at 20.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic write_hilo(input logic [15:0] hv, input logic [15:0] lv);
        lo_we = 1'b1; wdata = lv;
        @(negedge clk);
        lo_we = 1'b0; hi_we = 1'b1; wdata = hv;
        @(negedge clk);
        hi_we = 1'b0; wdata = 16'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; acc = 1'b0; signed_op = 1'b0; op_a = 16'h0; op_b = 16'h0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = 16'h0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({ready, done, hi, lo, mult_a, mult_b} !== {1'b1, 1'b0, 64'h0}) begin
            n_err++;
            $display("FAIL reset_state: got rdy=%b done=%b hi=%h lo=%h a=%h b=%h, want rdy=1 done=0 all 0",
                     ready, done, hi, lo, mult_a, mult_b);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int n;
        issue(16'd3, 16'd5, 1'b0, 1'b0);
        n_vec++;
        if (ready !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL basic_busy1: got rdy=%b done=%b, want rdy=0 done=0", ready, done);
        end
        @(negedge clk);
        n_vec++;
        if (ready !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL basic_busy2: got rdy=%b done=%b, want rdy=0 done=0", ready, done);
        end
        wait_done(n);
        n_vec++;
        if (n !== 1) begin
            n_err++;
            $display("FAIL basic_latency: done after %0d more cycles, want 1", n);
        end
        n_vec++;
        if ({ready, hi, lo} !== {1'b1, 32'h0000_000F}) begin
            n_err++;
            $display("FAIL basic_result: got rdy=%b hi=%h lo=%h, want rdy=1 hi=0000 lo=000f", ready, hi, lo);
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done_pulse: done=%b one cycle later, want 0", done);
        end
    endtask

    task automatic test_accumulate();
        int n;
        issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        wait_done(n);
        n_vec++;
        if ({hi, lo} !== 32'hFFFE_0001 || n !== LATENCY) begin
            n_err++;
            $display("FAIL max_product: got hi=%h lo=%h lat=%0d, want hi=fffe lo=0001 lat=%0d", hi, lo, n, LATENCY);
        end
        write_hilo(16'h0000, 16'h0001);
        n_vec++;
        if ({hi, lo} !== 32'h0000_0001) begin
            n_err++;
            $display("FAIL direct_write: got hi=%h lo=%h, want hi=0000 lo=0001", hi, lo);
        end
        issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        wait_done(n);
        n_vec++;
        if ({hi, lo} !== 32'hFFFE_0002) begin
            n_err++;
            $display("FAIL acc_max: got hi=%h lo=%h, want hi=fffe lo=0002", hi, lo);
        end
        write_hilo(16'h0000, 16'hFFFF);
        issue(16'd1, 16'd1, 1'b1, 1'b0);
        wait_done(n);
        n_vec++;
        if ({hi, lo} !== 32'h0001_0000) begin
            n_err++;
            $display("FAIL acc_carry: got hi=%h lo=%h, want hi=0001 lo=0000", hi, lo);
        end
        @(negedge clk);
    endtask

    task automatic test_wait_ignore();
        int n;
        int pulses;
        issue(16'd3, 16'd4, 1'b0, 1'b0);
        start = 1'b1; op_a = 16'd7; op_b = 16'd7; hi_we = 1'b1; lo_we = 1'b1; wdata = 16'h1234;
        @(negedge clk);
        start = 1'b0; op_a = 16'h0; op_b = 16'h0; hi_we = 1'b0; lo_we = 1'b0; wdata = 16'h0;
        wait_done(n);
        n_vec++;
        if ({hi, lo} !== 32'h0000_000C || mult_a !== 16'd3) begin
            n_err++;
            $display("FAIL wait_ignore: got hi=%h lo=%h a=%h, want hi=0000 lo=000c a=0003", hi, lo, mult_a);
        end
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        n_vec++;
        if (pulses !== 0 || ready !== 1'b1) begin
            n_err++;
            $display("FAIL wait_single_done: extra pulses=%0d rdy=%b, want 0 and rdy=1", pulses, ready);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        issue(16'd2, 16'd3, 1'b0, 1'b0);
        wait_done(n);
        n_vec++;
        if ({hi, lo} !== 32'h0000_0006 || ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_first: got hi=%h lo=%h rdy=%b, want hi=0000 lo=0006 rdy=1", hi, lo, ready);
        end
        issue(16'd4, 16'd5, 1'b1, 1'b0);
        n_vec++;
        if (ready !== 1'b0 || done !== 1'b0 || mult_a !== 16'd4) begin
            n_err++;
            $display("FAIL b2b_accept: got rdy=%b done=%b a=%h, want rdy=0 done=0 a=0004", ready, done, mult_a);
        end
        wait_done(n);
        n_vec++;
        if ({hi, lo} !== 32'h0000_001A || n !== LATENCY) begin
            n_err++;
            $display("FAIL b2b_second: got hi=%h lo=%h lat=%0d, want hi=0000 lo=001a lat=%0d", hi, lo, n, LATENCY);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int pulses;
        issue(16'd9, 16'd9, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({ready, hi, lo, mult_a} !== {1'b1, 48'h0}) begin
            n_err++;
            $display("FAIL rst_mid_state: got rdy=%b hi=%h lo=%h a=%h, want rdy=1 all 0", ready, hi, lo, mult_a);
        end
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        n_vec++;
        if (pulses !== 0 || ready !== 1'b1 || {hi, lo} !== 32'h0) begin
            n_err++;
            $display("FAIL rst_mid_abandon: pulses=%0d rdy=%b hi=%h lo=%h, want 0 1 0000 0000", pulses, ready, hi, lo);
        end
    endtask

    task automatic test_signed();
        int n;
        issue(16'hFFFE, 16'h0003, 1'b0, 1'b1);
        wait_done(n);
`ifdef MULT_SIGNED_EN
        n_vec++;
        if ({hi, lo} !== 32'hFFFF_FFFA) begin
            n_err++;
            $display("FAIL signed_neg2x3: got hi=%h lo=%h, want hi=ffff lo=fffa", hi, lo);
        end
        issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        wait_done(n);
        n_vec++;
        if ({hi, lo} !== 32'h0000_0001) begin
            n_err++;
            $display("FAIL signed_neg1xneg1: got hi=%h lo=%h, want hi=0000 lo=0001", hi, lo);
        end
        issue(16'hFFFE, 16'h0003, 1'b0, 1'b0);
        wait_done(n);
`endif
        n_vec++;
        if ({hi, lo} !== 32'h0002_FFFA) begin
            n_err++;
            $display("FAIL unsigned_fffe_x3: got hi=%h lo=%h, want hi=0002 lo=fffa", hi, lo);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_accumulate();
        test_wait_ignore();
        test_back_to_back();
        test_reset_mid();
        test_signed();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
